cpuc_fetch: RTL
===============

Name: cpuc_fetch

Overview:
- Program-counter and instruction-fetch stage of the CPUC.
- Holds the PROGRAM_SIZE-entry instruction memory and steps the PC.
- Hands instructions to the downstream decode/config stage over a valid/ready handshake.
- Drives the zero-extended PC value into the PC slot of the register-outputs bus consumed by the component crossbar.

Parameters:
- DATA_WIDTH, 32, width of pc_out and inst_count (matches the CPU data width)
- INST_WIDTH, 32, instruction word width
- PROGRAM_SIZE, 32, instruction memory depth; must be a power of two
- PC_WIDTH, $clog2(PROGRAM_SIZE), PC / address width

Ports:
- Clk  in  1  clock, all state on rising edge
- Rst  in  1  asynchronous active-high reset
- start  in  1  pulse; IDLE/HALT -> RUN
- stop  in  1  pulse; RUN -> HALT
- br_valid  in  1  redirect request from comparator/equal result
- br_target  in  PC_WIDTH  redirect address
- prog_we  in  1  instruction memory write enable
- prog_addr  in  PC_WIDTH  write address
- prog_wdata  in  INST_WIDTH  write data
- inst_valid  out  1  output register holds an instruction
- inst_ready  in  1  downstream accepts instruction
- inst  out  INST_WIDTH  fetched instruction
- inst_pc  out  PC_WIDTH  address of inst
- pc_out  out  DATA_WIDTH  {zeros, fetch_pc}, feeds register-outputs PC slot
- state  out  2  0=IDLE, 1=RUN, 2=HALT
- inst_count  out  DATA_WIDTH  count of accepted instructions (valid && ready)

Behaviour:
- Reset (async, Rst=1): state=IDLE, fetch_pc=0, pc_out=0, inst_valid=0, inst=0, inst_pc=0, inst_count=0.
- Reset does not clear memory contents.
- Reset mid-operation discards any pending instruction immediately.
- Memory writes:
  - prog_we writes mem[prog_addr] at the edge, in any state.
  - A same-cycle read of the same address returns the old data (read-before-write).
- Issue condition: state==RUN && !br_valid && (!inst_valid || inst_ready).
- On issue (edge):
  - inst <= mem[fetch_pc], inst_pc <= fetch_pc, inst_valid <= 1.
  - fetch_pc <= fetch_pc+1, wrapping modulo PROGRAM_SIZE (PROGRAM_SIZE-1 -> 0).
  - Latency: 1 cycle from issue to inst_valid. Throughput: 1 instruction/cycle when inst_ready is held high.
- Accept without issue (inst_valid && inst_ready, no issue): inst_valid <= 0.
- Stall (inst_valid && !inst_ready): inst, inst_pc, fetch_pc all hold. Valid is never dropped without an accept or a flush.
- inst_count:
  - Increments on every cycle with inst_valid && inst_ready, in any state.
  - Wraps at 2^DATA_WIDTH.
- Branch (br_valid=1):
  - fetch_pc <= br_target; inst_valid <= 0 (flush, even if inst_ready=1; a flushed instruction is not counted).
  - No issue that cycle. Branch has priority over issue.
  - Honoured in every state, including IDLE/HALT (PC preset).
  - A simultaneous prog_we is still performed.
- FSM:
  - IDLE --start--> RUN
  - RUN --stop--> HALT
  - HALT --start--> RUN
  - start and stop in the same cycle: stop wins (RUN -> HALT; IDLE/HALT unchanged).
  - start while in RUN: ignored. stop while in IDLE: ignored.
- Stop semantics:
  - The transition to HALT takes effect at the edge.
  - Issue is still evaluated in that same cycle using the current state RUN, so at most one more instruction is fetched.
  - Thereafter no issue.
  - Any pending inst_valid is held until accepted; it is not flushed.
- Resume: HALT -> RUN continues from the current fetch_pc (not reset to 0).
- pc_out is always the registered fetch_pc, zero-extended to DATA_WIDTH.

Test Plan:
- Load mem[0..3]=0x11,0x22,0x33,0x44; pulse start; inst_ready=1 -> inst_valid rises 1 cycle after RUN; inst=0x11,0x22,0x33,0x44 on consecutive cycles; inst_pc=0..3; inst_count=4 after 4 accepts.
- RUN with inst_ready=0 for 3 cycles after the first instruction -> inst=0x11 and inst_pc=0 held; fetch_pc=1; inst_count unchanged; release ready -> 0x22 follows on the next cycle.
- fetch_pc=31 with PROGRAM_SIZE=32 -> next inst_pc=31, then 0; pc_out=0x00000000 after wrap.
- br_valid=1, br_target=5 while inst_valid=1 (inst_pc=2) and inst_ready=1 -> inst_valid=0 next cycle; inst_count not incremented for the flushed instruction; next inst_pc=5.
- start and stop asserted together in RUN -> state=HALT; one further issue at most; pending instruction still delivered on ready. A later start resumes at the held fetch_pc.
- Assert Rst mid-RUN with inst_valid=1 -> immediately state=IDLE, inst_valid=0, pc_out=0, inst_count=0. Memory contents retained: start -> inst=0x11 again.

Source files
------------

// File: rtl/cpuc_fetch.sv
// cpuc_fetch
// Program-counter and instruction-fetch stage of the CPUC. It holds the
// instruction memory, steps the fetch PC, and hands instructions to the
// decode/config stage over a valid/ready handshake.
//
// Ports
//   Clk, Rst      clock (rising edge) and asynchronous active-high reset
//   start, stop   run-control pulses (IDLE/HALT -> RUN, RUN -> HALT)
//   br_valid      redirect request; br_target is the new fetch PC
//   prog_we       instruction memory write (prog_addr, prog_wdata)
//   inst_valid    output register holds an instruction
//   inst_ready    downstream accepts the instruction this cycle
//   inst, inst_pc fetched instruction and its address
//   pc_out        fetch PC zero-extended, for the register-outputs PC slot
//   state         0=IDLE, 1=RUN, 2=HALT
//   inst_count    number of accepted instructions
module cpuc_fetch #(
    parameter int DATA_WIDTH   = 32,
    parameter int INST_WIDTH   = 32,
    parameter int PROGRAM_SIZE = 32,
    parameter int PC_WIDTH     = $clog2(PROGRAM_SIZE)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  br_valid,
    input  logic [PC_WIDTH-1:0]   br_target,
    input  logic                  prog_we,
    input  logic [PC_WIDTH-1:0]   prog_addr,
    input  logic [INST_WIDTH-1:0] prog_wdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [1:0]            state,
    output logic [DATA_WIDTH-1:0] inst_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetchState_t;

    fetchState_t           state_q, state_d;
    logic [PC_WIDTH-1:0]   fetchPc_q, fetchPc_d;
    logic                  valid_q, valid_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [PC_WIDTH-1:0]   instPc_q, instPc_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;

    logic [INST_WIDTH-1:0] mem [PROGRAM_SIZE];

    logic issue;
    logic accept;

    // Memory has no reset so a program survives Rst. The non-blocking write
    // makes a same-edge read of the same address return the old word.
    always_ff @(posedge Clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    // Issue uses the current state, so a stop in RUN still lets one more
    // instruction out on the edge that enters HALT.
    assign issue  = (state_q == RUN) && !br_valid && (!valid_q || inst_ready);
    // A flushed instruction is not a real accept, so it is not counted.
    assign accept = valid_q && inst_ready && !br_valid;

    // Run-control FSM; stop beats start when both arrive together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !stop) state_d = RUN;
            RUN:     if (stop)           state_d = HALT;
            HALT:    if (start && !stop) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next state. A branch preempts everything: it redirects the
    // PC and flushes the output register even when downstream is ready.
    always_comb begin
        fetchPc_d = fetchPc_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        instPc_d  = instPc_q;
        count_d   = count_q;

        if (accept) begin
            count_d = count_q + 1'b1;
        end

        if (br_valid) begin
            fetchPc_d = br_target;
            valid_d   = 1'b0;
        end else if (issue) begin
            inst_d    = mem[fetchPc_q];
            instPc_d  = fetchPc_q;
            valid_d   = 1'b1;
            fetchPc_d = fetchPc_q + 1'b1;
        end else if (accept) begin
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            fetchPc_q <= '0;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            instPc_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            fetchPc_q <= fetchPc_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            instPc_q  <= instPc_d;
            count_q   <= count_d;
        end
    end

    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = instPc_q;
    assign pc_out     = DATA_WIDTH'(fetchPc_q);
    assign state      = state_q;
    assign inst_count = count_q;

endmodule
